// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus types, zero constant
// and the fetch state encodings.
package if_fetch_pkg;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    localparam logic [1:0] IF_IDLE  = 2'd0;
    localparam logic [1:0] IF_FETCH = 2'd1;
    localparam logic [1:0] IF_HOLD  = 2'd2;

    localparam logic [2:0] BytesPerInst = 3'd4;

endpackage

// File: rtl/if_fetch.sv
// Byte-serial instruction fetch: issues four byte reads per instruction over a
// shared memory port, assembles them little-endian and holds the result for if_id.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_stall_i,
    input  logic        branch_enable_i,
    input  logic [31:0] branch_addr_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_din_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    logic [1:0] r_state;
    InstAddrBus r_pc;
    logic [2:0] r_ic;
    logic [2:0] r_cc;
    logic       r_pend;
    logic [7:0] r_bytes [0:3];
    InstBus     r_inst;
    logic       r_valid;

    logic w_req;
    logic w_issue;
    logic w_last;

    // The request stays up for the whole issue phase even without a grant.
    assign w_req      = rdy && (r_state == IF_FETCH) && (r_ic < BytesPerInst);
    assign w_issue    = w_req && mem_grant_i;
    assign w_last     = r_pend && (r_cc == (BytesPerInst - 3'd1));

    assign mem_req_o    = w_req;
    assign mem_addr_o   = w_req ? (r_pc + {29'd0, r_ic}) : ZeroWord;
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IF_IDLE;
            r_pc    <= ZeroWord;
            r_ic    <= 3'd0;
            r_cc    <= 3'd0;
            r_pend  <= 1'b0;
            r_inst  <= ZeroWord;
            r_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_bytes[i] <= 8'h00;
            end
        end else if (rdy) begin
            // A redirect clears pend, so the byte for any address issued now is dropped.
            if (branch_enable_i) begin
                r_state <= IF_FETCH;
                r_pc    <= branch_addr_i;
                r_ic    <= 3'd0;
                r_cc    <= 3'd0;
                r_pend  <= 1'b0;
                r_inst  <= ZeroWord;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    IF_IDLE: begin
                        r_state <= IF_FETCH;
                    end
                    IF_FETCH: begin
                        r_pend <= w_issue;
                        if (w_issue) begin
                            r_ic <= r_ic + 3'd1;
                        end
                        if (r_pend) begin
                            r_bytes[r_cc[1:0]] <= mem_din_i;
                            r_cc               <= r_cc + 3'd1;
                        end
                        // The last byte bypasses the bank so the word is ready one cycle earlier.
                        if (w_last) begin
                            r_inst  <= {mem_din_i, r_bytes[2], r_bytes[1], r_bytes[0]};
                            r_valid <= 1'b1;
                            r_state <= IF_HOLD;
                        end
                    end
                    IF_HOLD: begin
                        if (!if_stall_i) begin
                            r_state <= IF_FETCH;
                            r_pc    <= r_pc + 32'd4;
                            r_ic    <= 3'd0;
                            r_cc    <= 3'd0;
                            r_pend  <= 1'b0;
                            r_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IF_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the fetch stage.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_stall_i;
    logic        branch_enable_i;
    logic [31:0] branch_addr_i;
    logic        mem_grant_i;
    logic [7:0]  mem_din_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    int checks   = 0;
    int failures = 0;
    int cycleNo  = 0;

    logic        mStarted;
    logic        mHolding;
    logic [31:0] mPc;
    int          mIssued;
    int          mCaptured;
    logic        mPend;
    logic        mValid;
    logic [31:0] mInst;

    logic [31:0] issueLog [$];
    int          issueCycle [$];

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .if_stall_i     (if_stall_i),
        .branch_enable_i(branch_enable_i),
        .branch_addr_i  (branch_addr_i),
        .mem_grant_i    (mem_grant_i),
        .mem_din_i      (mem_din_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .inst_valid_o   (inst_valid_o)
    );

    always #5 clk = ~clk;

    // Memory image: the first word is addi a0,x0,0; everything else is a hash of the address.
    function automatic logic [7:0] memByte(input logic [31:0] a);
        case (a)
            32'h0:   return 8'h13;
            32'h1:   return 8'h05;
            32'h2:   return 8'h00;
            32'h3:   return 8'h00;
            default: return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {memByte(a + 32'd3), memByte(a + 32'd2), memByte(a + 32'd1), memByte(a)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mStarted  = 1'b0;
        mHolding  = 1'b0;
        mPc       = 32'h0;
        mIssued   = 0;
        mCaptured = 0;
        mPend     = 1'b0;
        mValid    = 1'b0;
        mInst     = 32'h0;
    endtask

    // Drives one clock cycle, checks all outputs against the model, then advances
    // the model and plays the memory side (data one cycle after a granted issue).
    task automatic applyStimulus(input logic iRdy, input logic iStall, input logic iBranch,
                                 input logic [31:0] iAddr, input logic iGrant);
        logic        expReq;
        logic [31:0] expAddr;
        logic        issued;
        rdy             = iRdy;
        if_stall_i      = iStall;
        branch_enable_i = iBranch;
        branch_addr_i   = iAddr;
        mem_grant_i     = iGrant;
        #2;
        expReq  = iRdy && mStarted && !mHolding && (mIssued < 4);
        expAddr = expReq ? (mPc + 32'(mIssued)) : 32'h0;
        checkOutput("mem_req_o", {31'd0, mem_req_o}, {31'd0, expReq});
        checkOutput("mem_addr_o", mem_addr_o, expAddr);
        checkOutput("pc_o", pc_o, mPc);
        checkOutput("inst_valid_o", {31'd0, inst_valid_o}, {31'd0, mValid});
        checkOutput("inst_o", inst_o, mInst);
        if (rdy && mem_req_o && mem_grant_i) begin
            issueLog.push_back(mem_addr_o);
            issueCycle.push_back(cycleNo);
        end
        issued = expReq && iGrant;
        @(posedge clk);
        cycleNo++;
        if (iRdy) begin
            if (iBranch) begin
                mPc       = iAddr;
                mIssued   = 0;
                mCaptured = 0;
                mPend     = 1'b0;
                mValid    = 1'b0;
                mInst     = 32'h0;
                mStarted  = 1'b1;
                mHolding  = 1'b0;
            end else if (!mStarted) begin
                mStarted = 1'b1;
            end else if (mHolding) begin
                if (!iStall) begin
                    mPc       = mPc + 32'd4;
                    mValid    = 1'b0;
                    mHolding  = 1'b0;
                    mIssued   = 0;
                    mCaptured = 0;
                    mPend     = 1'b0;
                end
            end else begin
                if (mPend) mCaptured++;
                if (issued) mIssued++;
                mPend = issued;
                if (mCaptured == 4) begin
                    mHolding = 1'b1;
                    mValid   = 1'b1;
                    mInst    = memWord(mPc);
                end
            end
        end
        #1;
        if (issued) mem_din_i = memByte(expAddr);
        else if (iRdy) mem_din_i = 8'($urandom);
    endtask

    task automatic runUntilValid(input string tag);
        for (int k = 0; k < 40 && inst_valid_o !== 1'b1; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        end
        checkOutput(tag, {31'd0, inst_valid_o}, 32'd1);
    endtask

    task automatic pulseReset();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_pc_o", pc_o, 32'h0);
        checkOutput("rst_inst_o", inst_o, 32'h0);
        checkOutput("rst_inst_valid_o", {31'd0, inst_valid_o}, 32'd0);
        checkOutput("rst_mem_req_o", {31'd0, mem_req_o}, 32'd0);
        checkOutput("rst_mem_addr_o", mem_addr_o, 32'h0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_din_i = 8'($urandom);
        issueLog.delete();
        issueCycle.delete();
    endtask

    initial begin
        int sz;
        rst             = 1'b1;
        rdy             = 1'b0;
        if_stall_i      = 1'b0;
        branch_enable_i = 1'b0;
        branch_addr_i   = 32'h0;
        mem_grant_i     = 1'b0;
        mem_din_i       = 8'h00;
        modelReset();
        #1;
        checkOutput("init_pc_o", pc_o, 32'h0);
        checkOutput("init_inst_o", inst_o, 32'h0);
        checkOutput("init_inst_valid_o", {31'd0, inst_valid_o}, 32'd0);
        checkOutput("init_mem_req_o", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] first fetch from 0x0 with continuous grant");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        runUntilValid("req019_valid");
        checkOutput("req019_issue0", issueLog[0], 32'h0);
        checkOutput("req019_issue1", issueLog[1], 32'h1);
        checkOutput("req019_issue2", issueLog[2], 32'h2);
        checkOutput("req019_issue3", issueLog[3], 32'h3);
        checkOutput("req019_consecutive", 32'(issueCycle[3] - issueCycle[0]), 32'd3);
        checkOutput("req019_latency", 32'(cycleNo - issueCycle[0]), 32'd5);
        checkOutput("req019_inst", inst_o, 32'h0000_0513);
        checkOutput("req019_pc", pc_o, 32'h0);

        $display("[TB] stall while holding, then consume");
        sz = issueLog.size();
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("req020_no_issue", 32'(issueLog.size()), 32'(sz));
        checkOutput("req020_inst_stable", inst_o, 32'h0000_0513);
        checkOutput("req020_valid_stable", {31'd0, inst_valid_o}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("req020_next_issue", issueLog[issueLog.size() - 1], 32'h4);

        $display("[TB] grant gap after two issues");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        sz = issueLog.size();
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("req021_gap_silent", 32'(issueLog.size()), 32'(sz));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("req021_resume", issueLog[issueLog.size() - 1], 32'h6);
        runUntilValid("req021_valid");
        checkOutput("req021_pc", pc_o, 32'h4);
        checkOutput("req021_inst", inst_o, memWord(32'h4));

        $display("[TB] redirect after three issues at 0x8");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("req022_third_issue", issueLog[issueLog.size() - 1], 32'hA);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_1000, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("req022_target_issue", issueLog[issueLog.size() - 1], 32'h1000);
        runUntilValid("req022_valid");
        checkOutput("req022_pc", pc_o, 32'h1000);
        checkOutput("req022_inst", inst_o, memWord(32'h1000));

        $display("[TB] redirect colliding with consume at 0x10");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 1'b1);
        runUntilValid("req023_valid10");
        checkOutput("req023_pc10", pc_o, 32'h10);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h2000, 1'b1);
        checkOutput("req023_pc_target", pc_o, 32'h2000);
        checkOutput("req023_inst_cleared", inst_o, 32'h0);
        runUntilValid("req023_valid2000");
        checkOutput("req023_pc_final", pc_o, 32'h2000);

        $display("[TB] pc wrap at top of address space");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        runUntilValid("wrap_valid");
        checkOutput("wrap_inst", inst_o, memWord(32'hFFFF_FFFC));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_pc", pc_o, 32'h0);

        $display("[TB] reset mid-fetch at 0x40");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("req024_pre_pc", pc_o, 32'h40);
        pulseReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("req024_first_issue", issueLog[0], 32'h0);
        // A byte is pending here; it must survive two frozen cycles.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0800, 1'b1);
        runUntilValid("req013_valid");
        checkOutput("req013_inst", inst_o, 32'h0000_0513);
        checkOutput("req013_pc", pc_o, 32'h0);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            logic [31:0] target;
            case ($urandom_range(0, 3))
                0:       target = 32'hFFFF_FFFC;
                1:       target = 32'hFFFF_FFFE;
                default: target = $urandom;
            endcase
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 15) == 0, target, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, ports named clk and rst.
REQ-002 SHALL expose these ports (name  direction  width  meaning):
  clk  in  1  system clock
  rst  in  1  async active-high reset
  rdy  in  1  global ready; low freezes all state
  if_stall_i  in  1  if_id cannot accept an instruction this cycle
  branch_enable_i  in  1  one-cycle redirect pulse from decode
  branch_addr_i  in  32  redirect target PC
  mem_grant_i  in  1  memory arbiter grants the byte port this cycle
  mem_din_i  in  8  read byte for the address issued the previous cycle
  mem_req_o  out  1  fetch requests the memory port
  mem_addr_o  out  32  byte address issued this cycle
  pc_o  out  32  PC of the presented instruction
  inst_o  out  32  assembled little-endian instruction
  inst_valid_o  out  1  pc_o/inst_o valid for if_id

Function
REQ-003 SHALL run the state machine IDLE -> FETCH -> HOLD -> FETCH.
  - IDLE: entered only from reset; moves to FETCH on the first cycle rdy=1.
REQ-004 FETCH SHALL keep issue count ic (0..4) and capture count cc (0..4), plus flag pend.
  - pend: a byte was issued last cycle.
REQ-005 In FETCH with ic<4 and mem_grant_i=1, SHALL drive mem_req_o=1 and mem_addr_o=pc+ic, then increment ic.
  - With mem_grant_i=0, SHALL issue nothing and hold ic.
REQ-006 When pend=1, SHALL capture mem_din_i into instruction byte cc (byte 0 -> bits 7:0) and increment cc, regardless of grant.
REQ-007 SHALL keep mem_req_o=1 throughout FETCH while ic<4.
  - mem_req_o SHALL be 0 in IDLE and HOLD.
REQ-008 When cc reaches 4, SHALL enter HOLD next cycle with inst_valid_o=1.
  - Minimum latency with continuous grant: 5 cycles from the first issue to inst_valid_o.
REQ-009 In HOLD, a cycle with if_stall_i=0 SHALL consume the instruction.
  - Next cycle: pc=pc+4 (32-bit wrap at 0xFFFFFFFC -> 0x00000000), inst_valid_o=0, state FETCH, ic=cc=0.
REQ-010 In HOLD with if_stall_i=1, SHALL keep pc_o, inst_o and inst_valid_o stable.
REQ-011 On branch_enable_i=1, SHALL set pc=branch_addr_i next cycle.
  - Also next cycle: discard partial or held instruction, clear ic/cc/pend, inst_valid_o=0, state FETCH.
  - The byte returned for an already-issued address SHALL be ignored.
REQ-012 Priority SHALL be: rst > rdy=0 > branch_enable_i > consume/stall > fetch progress.
  - branch_enable_i coinciding with a consume SHALL redirect, not increment.
REQ-013 rdy=0 SHALL freeze all registers and force mem_req_o=0.
  - A byte pending across a rdy=0 cycle SHALL still be captured on the next rdy=1 cycle (memory holds mem_din_i while rdy=0).
REQ-014 inst_o SHALL be registered.
  - inst_o SHALL change only on the cycle inst_valid_o rises, or be cleared to 0 on redirect or reset.

Reset
REQ-015 While rst=1, asynchronously: state=IDLE, pc=0x00000000, ic=cc=0, pend=0.
  - Outputs: inst_o=0, pc_o=0, inst_valid_o=0, mem_req_o=0, mem_addr_o=0.
REQ-016 Reset asserted mid-fetch SHALL abandon the fetch.
  - After release, fetch SHALL restart at 0x00000000 from byte 0.

Structure
REQ-017 The shared defines file SHALL hold ZeroWord, InstAddrBus, InstBus, and the fetch state encodings IF_IDLE/IF_FETCH/IF_HOLD.
REQ-018 SHALL be a single module with no sub-module.
  - Byte assembly is a 4x8 register bank inside if_fetch.

Verification
REQ-019 Reset release, grant always 1, memory bytes 13 05 00 00 at 0x0 -> addresses 0,1,2,3 issued on consecutive cycles; inst_o=0x00000513 and pc_o=0 with inst_valid_o=1 five cycles after the first issue.
REQ-020 if_stall_i=1 for 3 cycles while valid -> outputs stable 3 cycles, no mem_req_o; on release, next fetch issues 0x4.
REQ-021 Grant dropped after 2 issues for 4 cycles -> byte 1 still captured, no issue during the gap, resumes at pc+2; assembled word correct.
REQ-022 branch_enable_i with branch_addr_i=0x00001000 after 3 issues at pc=0x8 -> stale byte ignored, next issue 0x1000, no instruction from 0x8 presented.
REQ-023 branch_enable_i in the same cycle as a consume at pc=0x10 -> next pc_o=0x2000 (branch target), never 0x14.
REQ-024 rst pulsed mid-fetch at pc=0x40 -> outputs zero immediately (asynchronously); after release, the first issue is at 0x0.
